// File: rtl/r2b_converter_i_pkg.sv
// Purpose: shared definitions for the row-to-block converter.
//   - Default geometry and the derived slice/beat counts for that geometry.
//   - Counter width helper, element typedef and the drain state encoding.
package r2b_converter_i_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_FRAC_WIDTH = 8;
  localparam int unsigned DEF_BLOCK_SIZE = 2;
  localparam int unsigned DEF_CHUNK_SIZE = 4;
  localparam int unsigned DEF_ROW        = 8;
  localparam int unsigned DEF_COL        = 6;
  localparam int unsigned DEF_NUM_CORES  = 2;

  // Derived for the default geometry.
  localparam int unsigned SLICE_ROWS = DEF_BLOCK_SIZE * DEF_NUM_CORES;
  localparam int unsigned BEATS      = DEF_COL / DEF_BLOCK_SIZE;

  typedef logic [DEF_WIDTH-1:0] elem_t;

  typedef enum logic {
    StIdle,
    StDrain
  } drain_st_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/r2b_slice_buf.sv
// Purpose: ping-pong slice buffer, two banks of SLICE_ROWS x COL elements.
// Ports:
//   clk          rising-edge clock
//   i_wr_en      write one full row this cycle
//   i_wr_bank    bank being filled
//   i_wr_row     row index inside the slice
//   i_wr_data    row data, element 0 at the MSB
//   i_rd_bank    bank being drained
//   i_rd_beat    column-block index to gather
//   o_rd_tiles   NUM_CORES tiles for that column-block, core 0 at the MSB
module r2b_slice_buf #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COL        = 6,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned SLICE_ROWS = BLOCK_SIZE * NUM_CORES,
  parameter int unsigned BEATS      = COL / BLOCK_SIZE,
  parameter int unsigned ROW_W      = 2,
  parameter int unsigned BEAT_W     = 2
) (
  input  logic                                          clk,
  input  logic                                          i_wr_en,
  input  logic                                          i_wr_bank,
  input  logic [ROW_W-1:0]                              i_wr_row,
  input  logic [WIDTH*COL-1:0]                          i_wr_data,
  input  logic                                          i_rd_bank,
  input  logic [BEAT_W-1:0]                             i_rd_beat,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0] o_rd_tiles
);

  localparam int unsigned RowBits   = WIDTH * COL;
  localparam int unsigned TileElems = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned OutElems  = TileElems * NUM_CORES;

  logic [RowBits-1:0] r_bank0 [SLICE_ROWS];
  logic [RowBits-1:0] r_bank1 [SLICE_ROWS];
  logic [RowBits-1:0] w_rows  [SLICE_ROWS];

  // Data storage needs no reset: bank validity is tracked by the top-level counters.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_bank) begin
        r_bank1[i_wr_row] <= i_wr_data;
      end else begin
        r_bank0[i_wr_row] <= i_wr_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SLICE_ROWS; i++) begin
      w_rows[i] = i_rd_bank ? r_bank1[i] : r_bank0[i];
    end
  end

  // Core k takes slice rows k*B..k*B+B-1; every core shares column-block i_rd_beat.
  always_comb begin
    o_rd_tiles = '0;
    for (int c = 0; c < BEATS; c++) begin
      if (int'(i_rd_beat) == c) begin
        for (int k = 0; k < NUM_CORES; k++) begin
          for (int r = 0; r < BLOCK_SIZE; r++) begin
            for (int q = 0; q < BLOCK_SIZE; q++) begin
              o_rd_tiles[WIDTH*(OutElems-(k*TileElems+r*BLOCK_SIZE+q))-1 -: WIDTH] =
                  w_rows[k*BLOCK_SIZE+r][WIDTH*(COL-(c*BLOCK_SIZE+q))-1 -: WIDTH];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/r2b_converter_i.sv
// Purpose: row-to-block converter. Captures one matrix row per beat into a
//   ping-pong slice buffer and, once a slice is complete, emits one beat per
//   column-block holding NUM_CORES BLOCK_SIZE x BLOCK_SIZE tiles.
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   en              global enable; low freezes all state
//   in_valid        in_n2r_buffer carries a row
//   in_n2r_buffer   one row, element 0 at the MSB
//   out_valid       out_n2r_buffer holds a new beat
//   slice_done      pulses with the last beat of a slice
//   out_n2r_buffer  NUM_CORES tiles, core 0 at the MSB
module r2b_converter_i
  import r2b_converter_i_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int unsigned CHUNK_SIZE = DEF_CHUNK_SIZE,
  parameter int unsigned ROW        = DEF_ROW,
  parameter int unsigned COL        = DEF_COL,
  parameter int unsigned NUM_CORES  = DEF_NUM_CORES
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                in_valid,
  input  logic [WIDTH*COL-1:0]                in_n2r_buffer,
  output logic                                out_valid,
  output logic                                slice_done,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_n2r_buffer
);

  localparam int unsigned SliceRows = BLOCK_SIZE * NUM_CORES;
  localparam int unsigned Beats     = COL / BLOCK_SIZE;
  localparam int unsigned Slices    = ROW / SliceRows;
  localparam int unsigned RowW      = cnt_width(SliceRows);
  localparam int unsigned BeatW     = cnt_width(Beats);
  localparam int unsigned SliceW    = cnt_width(Slices);
  localparam int unsigned OutW      = WIDTH * CHUNK_SIZE * NUM_CORES;

  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
    $error("CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
  end
  if ((ROW % SliceRows) != 0 || (COL % BLOCK_SIZE) != 0) begin : g_bad_geom
    $error("ROW/COL not divisible by the slice/tile geometry");
  end
  if (Beats > SliceRows) begin : g_bad_beats
    $error("drain would not finish before the next slice is filled");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH exceeds WIDTH");
  end

  logic [RowW-1:0]   r_row_cnt;
  logic [BeatW-1:0]  r_beat_cnt;
  logic [SliceW-1:0] r_slice_cnt;
  logic              r_fill_bank;
  drain_st_e         r_state;
  logic [OutW-1:0]   r_out;
  logic              r_out_valid;
  logic              r_slice_done;

  logic            w_capture;
  logic            w_last_row;
  logic            w_last_beat;
  logic            w_last_slice;
  logic [OutW-1:0] w_tiles;

  assign w_capture    = en & in_valid;
  assign w_last_row   = (r_row_cnt == RowW'(SliceRows - 1));
  assign w_last_beat  = (r_beat_cnt == BeatW'(Beats - 1));
  assign w_last_slice = (r_slice_cnt == SliceW'(Slices - 1));

  // The drained bank is always the one not being filled.
  r2b_slice_buf #(
    .WIDTH      (WIDTH),
    .COL        (COL),
    .BLOCK_SIZE (BLOCK_SIZE),
    .NUM_CORES  (NUM_CORES),
    .SLICE_ROWS (SliceRows),
    .BEATS      (Beats),
    .ROW_W      (RowW),
    .BEAT_W     (BeatW)
  ) u_slice_buf (
    .clk        (clk),
    .i_wr_en    (w_capture),
    .i_wr_bank  (r_fill_bank),
    .i_wr_row   (r_row_cnt),
    .i_wr_data  (in_n2r_buffer),
    .i_rd_bank  (~r_fill_bank),
    .i_rd_beat  (r_beat_cnt),
    .o_rd_tiles (w_tiles)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_cnt    <= '0;
      r_beat_cnt   <= '0;
      r_slice_cnt  <= '0;
      r_fill_bank  <= 1'b0;
      r_state      <= StIdle;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_slice_done <= 1'b0;
    end else if (en) begin
      if (r_state == StDrain) begin
        r_out        <= w_tiles;
        r_out_valid  <= 1'b1;
        r_slice_done <= w_last_beat;
        r_beat_cnt   <= w_last_beat ? '0 : r_beat_cnt + BeatW'(1);
        if (w_last_beat) begin
          r_state <= StIdle;
        end
      end else begin
        r_out_valid  <= 1'b0;
        r_slice_done <= 1'b0;
      end

      if (in_valid) begin
        if (w_last_row) begin
          r_row_cnt   <= '0;
          r_fill_bank <= ~r_fill_bank;
          r_slice_cnt <= w_last_slice ? '0 : r_slice_cnt + SliceW'(1);
          // A completed slice starts its drain even if the previous one ends this edge.
          r_state     <= StDrain;
          r_beat_cnt  <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + RowW'(1);
        end
      end
    end
  end

  assign out_n2r_buffer = r_out;
  assign out_valid      = r_out_valid;
  assign slice_done     = r_slice_done;

endmodule

// File: tb/tb_r2b_converter_i.sv
module tb_r2b_converter_i;

  localparam int W    = 16;
  localparam int B    = 2;
  localparam int NC   = 2;
  localparam int COLS = 6;
  localparam int CH   = B * B;
  localparam int SR   = B * NC;
  localparam int NB   = COLS / B;
  localparam int RW   = W * COLS;
  localparam int OW   = W * CH * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic          out_valid;
  logic          slice_done;
  logic [OW-1:0] out_data;

  r2b_converter_i dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .in_valid       (in_valid),
    .in_n2r_buffer  (in_data),
    .out_valid      (out_valid),
    .slice_done     (slice_done),
    .out_n2r_buffer (out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          done;
  } exp_t;

  exp_t          q_exp[$];
  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] m_rows [SR];
  int            m_cnt = 0;
  logic [OW-1:0] first_beat = '0;
  bit            got_first = 1'b0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] elem_of(input logic [RW-1:0] row, input int j);
    logic [RW-1:0] s;
    s = row >> (W * (COLS - 1 - j));
    return s[W-1:0];
  endfunction

  // Reference: beat c, core k = slice rows k*B+r, columns c*B+q, row-major, core 0 first.
  task automatic push_slice();
    exp_t e;
    for (int c = 0; c < NB; c++) begin
      e.data = '0;
      for (int k = 0; k < NC; k++)
        for (int r = 0; r < B; r++)
          for (int q = 0; q < B; q++)
            e.data = (e.data << W) | OW'(elem_of(m_rows[k*B+r], c*B+q));
      e.done = (c == NB - 1);
      q_exp.push_back(e);
    end
  endtask

  function automatic logic [RW-1:0] pattern_row(input int i);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < COLS; j++) r = (r << W) | RW'((i * COLS + j) << 8);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Monitor / scoreboard: samples each edge's inputs, checks outputs 2 time units later.
  initial begin : monitor
    logic          s_en, s_rst, s_iv;
    logic [RW-1:0] s_d;
    logic [OW-1:0] prev_out;
    logic          prev_valid, prev_done;
    exp_t          e;
    prev_out   = '0;
    prev_valid = 1'b0;
    prev_done  = 1'b0;
    forever begin
      @(posedge clk);
      s_en  = en;
      s_rst = rst_n;
      s_iv  = in_valid;
      s_d   = in_data;
      #2;
      if (!s_rst) begin
        check("reset_out_valid", out_valid, 0);
        check("reset_slice_done", slice_done, 0);
        check("reset_out", out_data, 0);
        q_exp.delete();
        m_cnt = 0;
      end else if (!s_en) begin
        check("hold_out", out_data, prev_out);
        check("hold_valid", out_valid, prev_valid);
        check("hold_done", slice_done, prev_done);
      end else begin
        if (q_exp.size() != 0) begin
          check("beat_present", out_valid, 1);
          if (out_valid) begin
            e = q_exp.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_done", slice_done, e.done);
            if (!got_first) begin
              first_beat = out_data;
              got_first  = 1'b1;
            end
          end
        end else begin
          check("idle_valid", out_valid, 0);
          check("idle_done", slice_done, 0);
        end
        if (s_iv) begin
          m_rows[m_cnt] = s_d;
          if (m_cnt == SR - 1) begin
            m_cnt = 0;
            push_slice();
          end else begin
            m_cnt++;
          end
        end
      end
      prev_out   = out_data;
      prev_valid = out_valid;
      prev_done  = slice_done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step(input logic r, input logic e, input logic v, input logic [RW-1:0] d);
    @(negedge clk);
    rst_n    = r;
    en       = e;
    in_valid = v;
    in_data  = d;
  endtask

  initial begin : stimulus
    // Reset for two edges.
    repeat (2) step(1'b0, 1'b1, 1'b0, '0);

    // Two back-to-back frames of the reference pattern.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, pattern_row(i));
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);

    // Pause mid-drain; rows offered while disabled must be ignored.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, pattern_row(i));
    step(1'b1, 1'b1, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b1, rand_row());
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);

    // One idle cycle between rows.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, pattern_row(i));
      step(1'b1, 1'b1, 1'b0, '0);
    end
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);

    // Reset mid-fill, then reset mid-drain.
    repeat (2) step(1'b1, 1'b1, 1'b1, rand_row());
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, rand_row());
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, rand_row());
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, rand_row());
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic with random enable and valid.
    for (int n = 0; n < 400; n++)
      step(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), rand_row());

    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);

    check("first_beat_value", first_beat,
          OW'(128'h0000_0100_0600_0700_0C00_0D00_1200_1300));
    check("queue_drained", OW'(q_exp.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
